// File: rtl/uart_cfg_pkg.sv
// Shared types and helpers for the parametrised UART core.
// Optional parity support is selected with the UART_PARITY_EN macro.
package uart_cfg_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Clock cycles per oversampling tick, truncated
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned ovs);
    return clk_hz / (baud * ovs);
  endfunction

  // Width of the tick divider counter; at least one bit
  function automatic int unsigned calc_cnt_w(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  // Parity bit over up to 8 data bits (unused upper bits must be zero)
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running oversampling tick generator shared by transmitter and receiver.
module uart_tick_gen
  import uart_cfg_pkg::*;
#(
  parameter int unsigned DIV   = 10,
  parameter int unsigned CNT_W = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Divider counter wrapping at DIV-1
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_cfg_core.sv
// Parametrised full-duplex UART core (tx and rx FSMs sharing one tick).
// Define UART_PARITY_EN to add a parity bit to both directions.
module uart_cfg_core
  import uart_cfg_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVS        = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD, OVS);
  localparam int unsigned CNT_W = calc_cnt_w(DIV);
  localparam int unsigned TW    = $clog2(2 * OVS);
  localparam int unsigned BW    = $clog2(DATA_BITS);

  localparam logic [TW-1:0] BIT_END  = TW'(OVS - 1);
  localparam logic [TW-1:0] STOP_END = TW'(STOP_BITS * OVS - 1);
  localparam logic [TW-1:0] MID      = TW'(OVS / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

`ifdef UART_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
`endif

  logic tick;

  uart_tick_gen #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_tick (
    .clk_i  (clk),
    .rst_i  (reset),
    .tick_o (tick)
  );

  // ---------------------------------------------------------------- TX
  tx_state_e            tx_state_q;
  logic [TW-1:0]        tx_tcnt_q;
  logic [BW-1:0]        tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_q;
  logic                 tx_busy_q;
  logic                 tx_done_q;
`ifdef UART_PARITY_EN
  logic                 tx_par_q;
`endif

  // Transmit FSM; line, busy and done are registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_done_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: begin
          if (start) begin
            tx_state_q <= TX_START;
            tx_q       <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_shift_q <= tx_data;
            tx_tcnt_q  <= '0;
            tx_bit_q   <= '0;
`ifdef UART_PARITY_EN
            tx_par_q   <= parity_bit(8'(tx_data), ODD);
`endif
          end
        end
        TX_START: begin
          if (tick) begin
            if (tx_tcnt_q == BIT_END) begin
              tx_tcnt_q  <= '0;
              tx_state_q <= TX_DATA;
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end else begin
              tx_tcnt_q <= tx_tcnt_q + 1'b1;
            end
          end
        end
        TX_DATA: begin
          if (tick) begin
            if (tx_tcnt_q == BIT_END) begin
              tx_tcnt_q <= '0;
              if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                tx_state_q <= TX_PARITY;
                tx_q       <= tx_par_q;
`else
                tx_state_q <= TX_STOP;
                tx_q       <= 1'b1;
`endif
              end else begin
                tx_bit_q   <= tx_bit_q + 1'b1;
                tx_q       <= tx_shift_q[0];
                tx_shift_q <= tx_shift_q >> 1;
              end
            end else begin
              tx_tcnt_q <= tx_tcnt_q + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (tick) begin
            if (tx_tcnt_q == BIT_END) begin
              tx_tcnt_q  <= '0;
              tx_state_q <= TX_STOP;
              tx_q       <= 1'b1;
            end else begin
              tx_tcnt_q <= tx_tcnt_q + 1'b1;
            end
          end
        end
`endif
        TX_STOP: begin
          if (tick) begin
            if (tx_tcnt_q == STOP_END) begin
              tx_tcnt_q  <= '0;
              tx_state_q <= TX_IDLE;
              tx_busy_q  <= 1'b0;
              tx_done_q  <= 1'b1;
            end else begin
              tx_tcnt_q <= tx_tcnt_q + 1'b1;
            end
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
          tx_q       <= 1'b1;
          tx_busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

  // ---------------------------------------------------------------- RX
  logic [1:0]           rx_sync_q;
  logic                 rx_s;
  rx_state_e            rx_state_q;
  logic [TW-1:0]        rx_tcnt_q;
  logic [BW-1:0]        rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_done_q;
  logic                 frame_err_q;
`ifdef UART_PARITY_EN
  logic                 rx_par_q;
  logic                 parity_err_q;
`endif

  // Two-flop synchroniser, idles high so reset does not look like a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync_q <= '1;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx};
    end
  end

  assign rx_s = rx_sync_q[1];

  // Receive FSM: mid-start validation, centre sampling, early exit after stop sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q   <= RX_IDLE;
      rx_tcnt_q    <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_done_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_state_q <= RX_START;
            rx_tcnt_q  <= '0;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_tcnt_q == MID) begin
              rx_tcnt_q <= '0;
              rx_bit_q  <= '0;
              rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
            end else begin
              rx_tcnt_q <= rx_tcnt_q + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (rx_tcnt_q == BIT_END) begin
              rx_tcnt_q  <= '0;
              rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
              if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                rx_state_q <= RX_PARITY;
`else
                rx_state_q <= RX_STOP;
`endif
              end else begin
                rx_bit_q <= rx_bit_q + 1'b1;
              end
            end else begin
              rx_tcnt_q <= rx_tcnt_q + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (tick) begin
            if (rx_tcnt_q == BIT_END) begin
              rx_tcnt_q  <= '0;
              rx_par_q   <= rx_s;
              rx_state_q <= RX_STOP;
            end else begin
              rx_tcnt_q <= rx_tcnt_q + 1'b1;
            end
          end
        end
`endif
        RX_STOP: begin
          if (tick) begin
            if (rx_tcnt_q == BIT_END) begin
              rx_tcnt_q    <= '0;
              rx_data_q    <= rx_shift_q;
              frame_err_q  <= ~rx_s;
`ifdef UART_PARITY_EN
              parity_err_q <= (rx_par_q != parity_bit(8'(rx_shift_q), ODD));
`endif
              rx_done_q    <= 1'b1;
              rx_state_q   <= RX_IDLE;
            end else begin
              rx_tcnt_q <= rx_tcnt_q + 1'b1;
            end
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
`ifdef UART_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
